// File: rtl/fp_wb_arbiter_pkg.sv
// Shared constants and types for the FPU/integer writeback arbiter.
// Default widths match the 32 x XLEN register file.
package fp_wb_arbiter_pkg;

  localparam int unsigned FP_WB_XLEN          = 32;
  localparam int unsigned FP_WB_LOG2_XRF_SIZE = 5;
  localparam int unsigned FP_WB_FIFO_DEPTH    = 2;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SelNone = 2'd0,
    SelInt  = 2'd1,
    SelFifo = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/fp_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO buffering {rd, data} FPU results.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    o_full  = (r_count == (PW + 1)'(DEPTH));
    o_empty = (r_count == '0);
    w_push  = i_push && !o_full;
    w_pop   = i_pop && !o_empty;
    o_data  = r_mem[r_rptr];
    o_count = r_count;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observable through the count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Register-file write master: integer writeback has strict priority, late FPU
// results queue in a FIFO, and a pending scoreboard tracks in-flight FPU destinations.
module fp_wb_arbiter
  import fp_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN          = FP_WB_XLEN,
  parameter int unsigned LOG2_XRF_SIZE = FP_WB_LOG2_XRF_SIZE,
  parameter int unsigned FIFO_DEPTH    = FP_WB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          int_we,
  input  logic [LOG2_XRF_SIZE-1:0]      int_rd,
  input  logic [XLEN-1:0]               int_data,
  input  logic                          fpu_issue,
  input  logic [LOG2_XRF_SIZE-1:0]      fpu_issue_rd,
  input  logic                          fpu_valid,
  output logic                          fpu_ready,
  input  logic [LOG2_XRF_SIZE-1:0]      fpu_rd,
  input  logic [XLEN-1:0]               fpu_data,
  output logic                          RegWrite,
  output logic [LOG2_XRF_SIZE-1:0]      rd,
  output logic [XLEN-1:0]               datain,
  output logic [(1<<LOG2_XRF_SIZE)-1:0] pending,
  output logic                          wb_conflict
);

  localparam int unsigned NREG = 1 << LOG2_XRF_SIZE;
  localparam int unsigned EW   = LOG2_XRF_SIZE + XLEN;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  logic                     r_live;
  logic                     r_regwrite;
  logic [LOG2_XRF_SIZE-1:0] r_rd;
  logic [XLEN-1:0]          r_datain;
  logic [NREG-1:0]          r_pending;
  logic                     r_conflict;

  logic                     w_int_take;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [CW-1:0]            w_count;
  logic [EW-1:0]            w_head;
  logic [LOG2_XRF_SIZE-1:0] w_head_rd;
  logic [XLEN-1:0]          w_head_data;
  logic [NREG-1:0]          w_pending_nxt;
  logic                     w_conflict_hit;
  wb_sel_e                  w_sel;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({fpu_rd, fpu_data}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready looks only at registered state, so int_we never reaches it combinationally.
  always_comb begin
    fpu_ready   = r_live && (w_count < CW'(FIFO_DEPTH));
    w_push      = fpu_valid && fpu_ready && !w_full;
    w_head_rd   = w_head[EW-1:XLEN];
    w_head_data = w_head[XLEN-1:0];
    w_int_take  = int_we && (int_rd != '0);
    if (w_int_take)    w_sel = SelInt;
    else if (!w_empty) w_sel = SelFifo;
    else               w_sel = SelNone;
    w_pop = (w_sel == SelFifo);
  end

  // Clear for the popped entry first so a same-edge issue to that index wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head_rd] = 1'b0;
    if (fpu_issue && (fpu_issue_rd != '0)) w_pending_nxt[fpu_issue_rd] = 1'b1;
    w_conflict_hit = (int_we && r_pending[int_rd])
                  || (fpu_issue && r_pending[fpu_issue_rd])
                  || (w_push && (fpu_rd != '0) && !r_pending[fpu_rd]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_datain   <= '0;
      r_pending  <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_pending  <= w_pending_nxt;
      r_conflict <= r_conflict | w_conflict_hit;
      case (w_sel)
        SelInt: begin
          r_regwrite <= 1'b1;
          r_rd       <= int_rd;
          r_datain   <= int_data;
        end
        SelFifo: begin
          // x0 results drain from the FIFO but never reach the register file.
          r_regwrite <= (w_head_rd != '0);
          if (w_head_rd != '0) begin
            r_rd     <= w_head_rd;
            r_datain <= w_head_data;
          end
        end
        default: r_regwrite <= 1'b0;
      endcase
    end
  end

  always_comb begin
    RegWrite    = r_regwrite;
    rd          = r_rd;
    datain      = r_datain;
    pending     = r_pending;
    wb_conflict = r_conflict;
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Randomized bench for fp_wb_arbiter against a queue-based reference model.
module tb_fp_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int LG    = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            int_we;
  logic [LG-1:0]   int_rd;
  logic [XLEN-1:0] int_data;
  logic            fpu_issue;
  logic [LG-1:0]   fpu_issue_rd;
  logic            fpu_valid;
  logic            fpu_ready;
  logic [LG-1:0]   fpu_rd;
  logic [XLEN-1:0] fpu_data;
  logic            RegWrite;
  logic [LG-1:0]   rd;
  logic [XLEN-1:0] datain;
  logic [31:0]     pending;
  logic            wb_conflict;

  fp_wb_arbiter #(
    .XLEN          (XLEN),
    .LOG2_XRF_SIZE (LG),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .int_we       (int_we),
    .int_rd       (int_rd),
    .int_data     (int_data),
    .fpu_issue    (fpu_issue),
    .fpu_issue_rd (fpu_issue_rd),
    .fpu_valid    (fpu_valid),
    .fpu_ready    (fpu_ready),
    .fpu_rd       (fpu_rd),
    .fpu_data     (fpu_data),
    .RegWrite     (RegWrite),
    .rd           (rd),
    .datain       (datain),
    .pending      (pending),
    .wb_conflict  (wb_conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [LG+XLEN-1:0] m_q[$];
  logic [31:0]        m_pend = '0;
  logic               m_conf = 1'b0;
  logic               m_live = 1'b0;
  logic               m_we   = 1'b0;
  logic [LG-1:0]      m_rd   = '0;
  logic [XLEN-1:0]    m_data = '0;
  logic               m_skip = 1'b0;
  logic               m_accepted = 1'b0;
  logic [LG-1:0]      out_list[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    int_we = 0; int_rd = '0; int_data = '0;
    fpu_issue = 0; fpu_issue_rd = '0;
    fpu_valid = 0; fpu_rd = '0; fpu_data = '0;
  endtask

  // Apply one clock edge's worth of the rules to the model, using current inputs.
  task automatic model_edge();
    logic               rdy, take, hit;
    logic [LG+XLEN-1:0] head;
    logic [31:0]        np;
    rdy  = m_live && (m_q.size() < DEPTH);
    take = int_we && (int_rd != 0);
    hit  = (int_we && m_pend[int_rd]) || (fpu_issue && m_pend[fpu_issue_rd])
        || (fpu_valid && rdy && (fpu_rd != 0) && !m_pend[fpu_rd]);
    np = m_pend;
    m_skip = 1'b0;
    m_accepted = fpu_valid && rdy;
    if (take) begin
      m_we = 1'b1; m_rd = int_rd; m_data = int_data;
    end else if (m_q.size() > 0) begin
      head = m_q.pop_front();
      np[head[LG+XLEN-1:XLEN]] = 1'b0;
      m_we = (head[LG+XLEN-1:XLEN] != 0);
      if (m_we) begin
        m_rd = head[LG+XLEN-1:XLEN]; m_data = head[XLEN-1:0];
      end else begin
        m_skip = 1'b1;
      end
    end else begin
      m_we = 1'b0;
    end
    if (fpu_issue && (fpu_issue_rd != 0)) np[fpu_issue_rd] = 1'b1;
    if (m_accepted) m_q.push_back({fpu_rd, fpu_data});
    m_pend = np;
    m_conf = m_conf | hit;
    m_live = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".we"}, 64'(RegWrite), 64'(m_we));
    if (!m_skip) begin
      check_eq({tag, ".rd"}, 64'(rd), 64'(m_rd));
      check_eq({tag, ".data"}, 64'(datain), 64'(m_data));
    end
    check_eq({tag, ".pend"}, 64'(pending), 64'(m_pend));
    check_eq({tag, ".conf"}, 64'(wb_conflict), 64'(m_conf));
    check_eq({tag, ".rdy"}, 64'(fpu_ready), 64'(m_live && (m_q.size() < DEPTH)));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #1;
    check_eq("rst.we", 64'(RegWrite), 64'd0);
    check_eq("rst.rd", 64'(rd), 64'd0);
    check_eq("rst.data", 64'(datain), 64'd0);
    check_eq("rst.pend", 64'(pending), 64'd0);
    check_eq("rst.conf", 64'(wb_conflict), 64'd0);
    check_eq("rst.rdy", 64'(fpu_ready), 64'd0);
    m_q.delete(); out_list.delete();
    m_pend = '0; m_conf = 0; m_live = 0; m_we = 0; m_rd = '0; m_data = '0;
    m_accepted = 0; m_skip = 0;
    @(posedge clk);
    #1;
    check_eq("rst.hold_rdy", 64'(fpu_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst.rel_rdy", 64'(fpu_ready), 64'd0);
    step("rst_rel");
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    #2;
    do_reset();

    // Integer path only.
    int_we = 1; int_rd = 5'd5; int_data = 32'hDEADBEEF;
    step("int5");
    check_eq("int5.rd_const", 64'(rd), 64'd5);
    int_rd = '0; int_data = 32'h12345678;
    step("int0");
    set_idle();

    // FPU result alone.
    fpu_issue = 1; fpu_issue_rd = 5'd7;
    step("fpu_iss7");
    set_idle();
    step("fpu_w1");
    step("fpu_w2");
    fpu_valid = 1; fpu_rd = 5'd7; fpu_data = 32'h3F800000;
    step("fpu_acc7");
    set_idle();
    step("fpu_pop7");
    check_eq("fpu_pop7.rd_const", 64'(rd), 64'd7);

    // Contention: integer owns the port while two results queue up.
    fpu_issue = 1; fpu_issue_rd = 5'd8;
    step("cont_iss8");
    fpu_issue_rd = 5'd9;
    step("cont_iss9");
    fpu_issue = 0;
    int_we = 1; int_rd = 5'd1; int_data = 32'h11;
    fpu_valid = 1; fpu_rd = 5'd8; fpu_data = 32'h88;
    step("cont_i1");
    int_rd = 5'd2; int_data = 32'h22; fpu_rd = 5'd9; fpu_data = 32'h99;
    step("cont_i2");
    check_eq("cont.full_rdy", 64'(fpu_ready), 64'd0);
    fpu_valid = 0; int_rd = 5'd3; int_data = 32'h33;
    step("cont_i3");
    set_idle();
    step("cont_p8");
    check_eq("cont_p8.rd_const", 64'(rd), 64'd8);
    step("cont_p9");
    check_eq("cont_p9.rd_const", 64'(rd), 64'd9);

    // Conflicts are sticky until reset.
    fpu_issue = 1; fpu_issue_rd = 5'd8;
    step("conf_iss8");
    fpu_issue = 0; int_we = 1; int_rd = 5'd8; int_data = 32'hBAD;
    step("conf_int8");
    check_eq("conf_int8.const", 64'(wb_conflict), 64'd1);
    int_we = 0; fpu_issue = 1; fpu_issue_rd = 5'd8;
    step("conf_iss8b");
    set_idle();
    step("conf_idle");
    do_reset();

    // Same-edge pop and issue of x10: set wins.
    fpu_issue = 1; fpu_issue_rd = 5'd10;
    step("se_iss10");
    fpu_issue = 0; fpu_valid = 1; fpu_rd = 5'd10; fpu_data = 32'hA0A0;
    step("se_acc10");
    fpu_valid = 0; fpu_issue = 1; fpu_issue_rd = 5'd10;
    step("se_pop10");
    check_eq("se_pop10.pend10", 64'(pending[10]), 64'd1);
    set_idle();
    step("se_idle");
    do_reset();

    // Well-behaved random traffic: issues and results follow the scoreboard.
    for (int c = 0; c < 400; c++) begin
      logic [LG-1:0] r;
      if (m_accepted) fpu_valid = 0;
      if (!fpu_valid) begin
        if (out_list.size() > 0 && ($urandom % 3 == 0)) begin
          int idx = $urandom_range(0, out_list.size() - 1);
          fpu_rd = out_list[idx];
          out_list.delete(idx);
          fpu_data = $urandom; fpu_valid = 1;
        end else if ($urandom % 16 == 0) begin
          fpu_rd = '0; fpu_data = $urandom; fpu_valid = 1;
        end
      end
      r = LG'($urandom);
      fpu_issue = ($urandom % 4 == 0) && !m_pend[r];
      fpu_issue_rd = r;
      int_rd = LG'($urandom);
      int_data = $urandom;
      int_we = ($urandom % 3 == 0) && !m_pend[int_rd];
      step("randA");
      if (fpu_issue && (r != 0)) out_list.push_back(r);
    end
    set_idle();
    for (int c = 0; c < 4; c++) step("drainA");
    do_reset();

    // Unconstrained random traffic, holding FPU data while stalled.
    for (int c = 0; c < 400; c++) begin
      if (!(fpu_valid && !m_accepted)) begin
        fpu_valid = $urandom % 2;
        fpu_rd = LG'($urandom);
        fpu_data = $urandom;
      end
      fpu_issue = $urandom % 3 == 0;
      fpu_issue_rd = LG'($urandom);
      int_we = $urandom % 2;
      int_rd = LG'($urandom);
      int_data = $urandom;
      step("randB");
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
